// File: rtl/tdc_event_builder.sv
// tdc_event_builder: turns TDC coarse/fine hit measurements into fine-bin durations and buffers them in a FIFO.
// Define TDC_EVB_TIMESTAMP_EN to tag each event with a free-running timestamp in the word MSBs.
module tdc_event_builder #(
   parameter int COUNT_W = 4,
   parameter int BIN_W   = 3,
   parameter int DEPTH   = 8,
   parameter int TS_W    = 16,
`ifdef TDC_EVB_TIMESTAMP_EN
   localparam int TS_EN  = 1,
`else
   localparam int TS_EN  = 0,
`endif
   localparam int W      = 1 + COUNT_W + BIN_W + ((TS_EN != 0) ? TS_W : 0)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [BIN_W-1:0]   bin_out_start,
   input  logic [BIN_W-1:0]   bin_out_stop,
   input  logic [COUNT_W-1:0] out_count,
   input  logic               rd_en,
   output logic [W-1:0]       rd_data,
   output logic               rd_valid,
   output logic               empty,
   output logic               full,
   output logic [7:0]         drop_count
);

   localparam int DUR_W = COUNT_W + BIN_W;
   localparam int AW    = $clog2(DEPTH);

   logic [DUR_W:0] dur_raw;
   logic [W-1:0]   word_next;
   logic [W-1:0]   s1_word;
   logic           s1_valid;
   logic [W-1:0]   mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [AW:0]    wr_ptr_next;
   logic [AW:0]    rd_ptr_next;
   logic           do_rd;
   logic           do_wr;
   logic           do_drop;

`ifdef TDC_EVB_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts_cnt <= '0;
      else     ts_cnt <= ts_cnt + 1'b1;
   end
`endif

   // The MSB of dur_raw can only be set by a negative result (zero coarse count, stop bin below start bin).
   always_comb begin
      dur_raw = {1'b0, out_count, {BIN_W{1'b0}}}
              + {{(COUNT_W + 1){1'b0}}, bin_out_stop}
              - {{(COUNT_W + 1){1'b0}}, bin_out_start};
      word_next = '0;
      word_next[DUR_W] = dur_raw[DUR_W];
      word_next[DUR_W-1:0] = dur_raw[DUR_W] ? '0 : dur_raw[DUR_W-1:0];
`ifdef TDC_EVB_TIMESTAMP_EN
      word_next[W-1 -: TS_W] = ts_cnt;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_word  <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) s1_word <= word_next;
      end
   end

   // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
   always_comb begin
      do_rd       = rd_en && !empty;
      do_wr       = s1_valid && (!full || do_rd);
      do_drop     = s1_valid && full && !do_rd;
      wr_ptr_next = do_wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr_next = do_rd ? rd_ptr + 1'b1 : rd_ptr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
         empty  <= (wr_ptr_next == rd_ptr_next);
         full   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                   (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= s1_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= do_rd;
         if (do_rd) rd_data <= mem[rd_ptr[AW-1:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_count <= '0;
      end else if (do_drop && (drop_count != 8'hFF)) begin
         drop_count <= drop_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_tdc_event_builder.sv
// Directed self-checking bench for tdc_event_builder (default parameters).
// Timestamp scenarios run only when TDC_EVB_TIMESTAMP_EN is defined.
module tb_tdc_event_builder;

`ifdef TDC_EVB_TIMESTAMP_EN
   localparam int W = 1 + 4 + 3 + 16;
`else
   localparam int W = 1 + 4 + 3;
`endif

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [2:0]   bin_out_start;
   logic [2:0]   bin_out_stop;
   logic [3:0]   out_count;
   logic         rd_en;
   logic [W-1:0] rd_data;
   logic         rd_valid;
   logic         empty;
   logic         full;
   logic [7:0]   drop_count;

   int vectors;
   int miscompares;

   tdc_event_builder dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .bin_out_start (bin_out_start),
      .bin_out_stop  (bin_out_stop),
      .out_count     (out_count),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .empty         (empty),
      .full          (full),
      .drop_count    (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   // Presents one measurement for exactly one sampling edge.
   task automatic send_event(input logic [3:0] c, input logic [2:0] s, input logic [2:0] p);
      in_valid      = 1'b1;
      out_count     = c;
      bin_out_start = s;
      bin_out_stop  = p;
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (rd_data !== '0) begin miscompares++; $display("[TB] FAIL reset_rd_data got %h want 0", rd_data); end
      vectors++;
      if (rd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_valid got %b want 0", rd_valid); end
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
      vectors++;
      if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full got %b want 0", full); end
      vectors++;
      if (drop_count !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_drop got %0d want 0", drop_count); end
      tick(2);
      rst = 1'b0;
      tick(2);
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_empty got %b want 1", empty); end
   endtask

   task automatic test_single();
      do_reset();
      send_event(4'd3, 3'd2, 3'd5);
      tick(1);
      vectors++;
      if (empty !== 1'b0) begin miscompares++; $display("[TB] FAIL single_empty_after_write got %b want 0", empty); end
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      vectors++;
      if (rd_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_rd_valid got %b want 1", rd_valid); end
      vectors++;
      if (rd_data[7:0] !== 8'd27) begin miscompares++; $display("[TB] FAIL single_rd_data got %h want 1b", rd_data[7:0]); end
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL single_empty_after_read got %b want 1", empty); end
      tick(1);
      vectors++;
      if (rd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_rd_valid_pulse got %b want 0", rd_valid); end
   endtask

   task automatic test_negative();
      do_reset();
      send_event(4'd0, 3'd6, 3'd1);
      send_event(4'd15, 3'd0, 3'd7);
      tick(1);
      rd_en = 1'b1;
      tick(1);
      vectors++;
      if (rd_data[7:0] !== 8'h80) begin miscompares++; $display("[TB] FAIL negative_err got %h want 80", rd_data[7:0]); end
      tick(1);
      rd_en = 1'b0;
      vectors++;
      if (rd_data[7:0] !== 8'h7F) begin miscompares++; $display("[TB] FAIL max_duration got %h want 7f", rd_data[7:0]); end
      vectors++;
      if (rd_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL max_duration_valid got %b want 1", rd_valid); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      do_reset();
      for (int i = 0; i < 8; i++) send_event(4'(i), 3'd0, 3'd1);
      tick(1);
      vectors++;
      if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_full8 got %b want 1", full); end
      vectors++;
      if (drop_count !== 8'd0) begin miscompares++; $display("[TB] FAIL overflow_drop8 got %0d want 0", drop_count); end
      send_event(4'd8, 3'd0, 3'd1);
      send_event(4'd9, 3'd0, 3'd1);
      tick(1);
      vectors++;
      if (drop_count !== 8'd2) begin miscompares++; $display("[TB] FAIL overflow_drop got %0d want 2", drop_count); end
      vectors++;
      if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_full10 got %b want 1", full); end
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         exp = 8'(8 * i + 1);
         vectors++;
         if (rd_valid !== 1'b1 || rd_data[7:0] !== exp) begin
            miscompares++;
            $display("[TB] FAIL overflow_read%0d got %b/%h want 1/%h", i, rd_valid, rd_data[7:0], exp);
         end
      end
      rd_en = 1'b0;
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_drained got %b want 1", empty); end
   endtask

   task automatic test_simul_full();
      logic [7:0] exp;
      do_reset();
      for (int i = 0; i < 8; i++) send_event(4'(i), 3'd0, 3'd2);
      send_event(4'd9, 3'd0, 3'd3);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      vectors++;
      if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_full_full got %b want 1", full); end
      vectors++;
      if (drop_count !== 8'd0) begin miscompares++; $display("[TB] FAIL simul_full_drop got %0d want 0", drop_count); end
      vectors++;
      if (rd_valid !== 1'b1 || rd_data[7:0] !== 8'd2) begin
         miscompares++;
         $display("[TB] FAIL simul_full_read got %b/%h want 1/02", rd_valid, rd_data[7:0]);
      end
      rd_en = 1'b1;
      for (int i = 1; i < 9; i++) begin
         tick(1);
         exp = (i == 8) ? 8'd75 : 8'(8 * i + 2);
         vectors++;
         if (rd_valid !== 1'b1 || rd_data[7:0] !== exp) begin
            miscompares++;
            $display("[TB] FAIL simul_full_drain%0d got %b/%h want 1/%h", i, rd_valid, rd_data[7:0], exp);
         end
      end
      rd_en = 1'b0;
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_full_empty got %b want 1", empty); end
   endtask

   task automatic test_simul_empty();
      do_reset();
      send_event(4'd2, 3'd1, 3'd4);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      vectors++;
      if (rd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_empty_rd_valid got %b want 0", rd_valid); end
      vectors++;
      if (empty !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_empty_accepted got %b want 0", empty); end
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      vectors++;
      if (rd_valid !== 1'b1 || rd_data[7:0] !== 8'd19) begin
         miscompares++;
         $display("[TB] FAIL simul_empty_read got %b/%h want 1/13", rd_valid, rd_data[7:0]);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 5; i++) send_event(4'd1, 3'd0, 3'(i));
      tick(1);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      vectors++;
      if (rd_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL async_pre_valid got %b want 1", rd_valid); end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL async_empty got %b want 1", empty); end
      vectors++;
      if (rd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL async_rd_valid got %b want 0", rd_valid); end
      vectors++;
      if (drop_count !== 8'd0 || rd_data !== '0) begin
         miscompares++;
         $display("[TB] FAIL async_drop_data got %0d/%h want 0/0", drop_count, rd_data);
      end
      tick(1);
      rst = 1'b0;
      tick(3);
      vectors++;
      if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL async_after_release got %b want 1", empty); end
   endtask

`ifdef TDC_EVB_TIMESTAMP_EN
   task automatic test_timestamp();
      do_reset();
      tick(10);
      send_event(4'd1, 3'd0, 3'd0);
      tick(14);
      send_event(4'd2, 3'd0, 3'd0);
      tick(1);
      rd_en = 1'b1;
      tick(1);
      vectors++;
      if (rd_data[W-1 -: 16] !== 16'd10 || rd_data[7:0] !== 8'd8) begin
         miscompares++;
         $display("[TB] FAIL ts_10 got %0d/%h want 10/08", rd_data[W-1 -: 16], rd_data[7:0]);
      end
      tick(1);
      rd_en = 1'b0;
      vectors++;
      if (rd_data[W-1 -: 16] !== 16'd25) begin
         miscompares++;
         $display("[TB] FAIL ts_25 got %0d want 25", rd_data[W-1 -: 16]);
      end
      do_reset();
      tick(65535);
      send_event(4'd1, 3'd0, 3'd0);
      send_event(4'd1, 3'd0, 3'd0);
      tick(1);
      rd_en = 1'b1;
      tick(1);
      vectors++;
      if (rd_data[W-1 -: 16] !== 16'd65535) begin
         miscompares++;
         $display("[TB] FAIL ts_max got %0d want 65535", rd_data[W-1 -: 16]);
      end
      tick(1);
      rd_en = 1'b0;
      vectors++;
      if (rd_data[W-1 -: 16] !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL ts_wrap got %0d want 0", rd_data[W-1 -: 16]);
      end
   endtask
`endif

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b0;
      in_valid      = 1'b0;
      bin_out_start = '0;
      bin_out_stop  = '0;
      out_count     = '0;
      rd_en         = 1'b0;
      test_reset();
      test_single();
      test_negative();
      test_overflow();
      test_simul_full();
      test_simul_empty();
      test_async_reset();
`ifdef TDC_EVB_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
